// File: rtl/hash_stream_out_pkg.sv
// Shared widths and serializer state type for the hash output stage.
package hash_stream_out_pkg;

  localparam int HASH_W = 128;
  localparam int WORD_W = 32;
  localparam int BEATS  = HASH_W / WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/hash_stream_out_fifo.sv
// Synchronous hash FIFO with a registered show-ahead head word.
module hash_fifo
  import hash_stream_out_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = HASH_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] head_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rdata   = head_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Head register tracks the word at the next read pointer; a write landing
  // on that slot this edge is forwarded since the array still holds old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && (wr_ptr_q == rd_ptr_d)) head_q <= wdata;
      else                                   head_q <= mem[rd_ptr_d];
    end
  end

endmodule

// File: rtl/hash_stream_out.sv
// Captures validator hashes into a FIFO (dropping on overflow) and streams
// each one out as four 32-bit beats, most significant word first.
module hash_stream_out
  import hash_stream_out_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic [HASH_W-1:0]        i_hash,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [WORD_W-1:0]        o_data,
  output logic                     o_last,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [DROP_W-1:0]        o_drop_count
);

  ser_state_e         state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic [HASH_W-1:0]  shift_q, shift_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [HASH_W-1:0]  fifo_rdata;
  logic               hs, last_hs, drop;

  hash_fifo #(.DEPTH(DEPTH), .WIDTH(HASH_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (i_hash),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (o_level)
  );

  assign hs        = (state_q == SEND) && o_ready;
  assign last_hs   = hs && (beat_q == 2'(BEATS - 1));
  // Pop decision only looks at registered FIFO state, so a same-cycle push
  // into an empty FIFO can never be popped straight through.
  assign fifo_pop  = !fifo_empty && ((state_q == IDLE) || last_hs);
  assign fifo_push = i_valid && (!fifo_full || fifo_pop);
  assign drop      = i_valid && !fifo_push;

  assign o_valid = (state_q == SEND);
  assign o_last  = (state_q == SEND) && (beat_q == 2'(BEATS - 1));
  assign o_data  = (state_q == SEND) ? shift_q[HASH_W-1 -: WORD_W] : '0;
  assign o_drop_count = drop_q;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    shift_d = shift_q;
    drop_d  = drop_q;

    if (drop && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);

    case (state_q)
      IDLE: begin
        if (fifo_pop) begin
          state_d = SEND;
          beat_d  = '0;
          shift_d = fifo_rdata;
        end
      end
      SEND: begin
        if (last_hs) begin
          beat_d = '0;
          if (fifo_pop) begin
            shift_d = fifo_rdata;
          end else begin
            state_d = IDLE;
            shift_d = '0;
          end
        end else if (hs) begin
          beat_d  = beat_q + 2'd1;
          shift_d = {shift_q[HASH_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beat_q  <= '0;
      shift_q <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      shift_q <= shift_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_hash_stream_out.sv
// Scoreboard bench for hash_stream_out: stimulus queues expected beats,
// a negedge monitor checks every handshake and stall stability.
module tb_hash_stream_out;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_valid;
  logic [127:0] i_hash;
  logic         o_valid;
  logic         o_ready;
  logic [31:0]  o_data;
  logic         o_last;
  logic [3:0]   o_level;
  logic [15:0]  o_drop_count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [32:0] exp_q [$];

  hash_stream_out #(.DEPTH(8), .DROP_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (i_valid),
    .i_hash       (i_hash),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_data       (o_data),
    .o_last       (o_last),
    .o_level      (o_level),
    .o_drop_count (o_drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  task automatic expect_hash(input logic [127:0] h);
    exp_q.push_back({1'b0, h[127:96]});
    exp_q.push_back({1'b0, h[95:64]});
    exp_q.push_back({1'b0, h[63:32]});
    exp_q.push_back({1'b1, h[31:0]});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      next_cycle();
      n++;
    end
    check({name, "_drained"}, 128'(exp_q.size()), 128'd0);
  endtask

  // Monitor: compare each handshake against the scoreboard and verify that
  // a stalled beat holds data/last/valid until accepted.
  logic        stall_pending = 1'b0;
  logic [32:0] held_beat;

  always @(negedge clk) begin
    if (rst) begin
      stall_pending <= 1'b0;
    end else begin
      if (stall_pending) begin
        check("stall_valid", 128'(o_valid), 128'd1);
        check("stall_beat", 128'({o_last, o_data}), 128'(held_beat));
      end
      if (o_valid && o_ready) begin
        stall_pending <= 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 128'({o_last, o_data}), 128'd0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          total_cnt++;
          if ({o_last, o_data} === e) pass_cnt++;
          else $display("FAIL beat actual last=%0b data=%08h required last=%0b data=%08h",
                        o_last, o_data, e[32], e[31:0]);
        end
      end else if (o_valid) begin
        stall_pending <= 1'b1;
        held_beat     <= {o_last, o_data};
      end else begin
        stall_pending <= 1'b0;
      end
    end
  end

  logic [127:0] burst [13];
  localparam logic [127:0] HASH_A = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] HASH_B = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] HASH_C = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] HASH_D = 128'hD0D0D0D0_D1D1D1D1_D2D2D2D2_D3D3D3D3;
  localparam logic [127:0] HASH_E = 128'hE0E0E0E0_E1E1E1E1_E2E2E2E2_E3E3E3E3;

  initial begin
    rst = 1'b1; i_valid = 1'b0; i_hash = '0; o_ready = 1'b0;
    for (int i = 0; i < 13; i++) burst[i] = {4{32'hA000_0000 + 32'(i)}};

    // Reset state
    next_cycle(); next_cycle();
    rst = 1'b0;
    next_cycle();
    check("rst_valid", 128'(o_valid), 128'd0);
    check("rst_data",  128'(o_data),  128'd0);
    check("rst_last",  128'(o_last),  128'd0);
    check("rst_level", 128'(o_level), 128'd0);
    check("rst_drop",  128'(o_drop_count), 128'd0);

    // Single hash, latency
    o_ready = 1'b1; i_valid = 1'b1; i_hash = HASH_A;
    exp_q.push_back({1'b0, 32'h00112233});
    exp_q.push_back({1'b0, 32'h44556677});
    exp_q.push_back({1'b0, 32'h8899AABB});
    exp_q.push_back({1'b1, 32'hCCDDEEFF});
    next_cycle();
    i_valid = 1'b0;
    check("lat_c1_level", 128'(o_level), 128'd1);
    check("lat_c1_valid", 128'(o_valid), 128'd0);
    next_cycle();
    check("lat_c2_valid", 128'(o_valid), 128'd1);
    check("lat_c2_data",  128'(o_data),  128'h00112233);
    check("lat_c2_level", 128'(o_level), 128'd0);
    drain("single", 50);

    // Backpressure with ready pattern 1,0,0,1
    i_valid = 1'b1; i_hash = HASH_B; expect_hash(HASH_B);
    for (int i = 0; i < 24; i++) begin
      o_ready = (i % 4 == 0) || (i % 4 == 3);
      next_cycle();
      i_valid = 1'b0;
    end
    o_ready = 1'b1;
    drain("backpressure", 50);

    // Burst of 12 with ready low: 1 in shift reg, 8 in FIFO, 3 dropped
    o_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      i_valid = 1'b1; i_hash = burst[i];
      if (i < 9) expect_hash(burst[i]);
      next_cycle();
    end
    i_valid = 1'b0;
    check("burst_level", 128'(o_level), 128'd8);
    check("burst_drop",  128'(o_drop_count), 128'd3);
    check("burst_valid", 128'(o_valid), 128'd1);
    o_ready = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    // Beat 3 of the first hash: push lands on the same edge as the pop
    check("full_pop_last", 128'(o_last), 128'd1);
    i_valid = 1'b1; i_hash = burst[12]; expect_hash(burst[12]);
    next_cycle();
    i_valid = 1'b0;
    check("full_pop_level", 128'(o_level), 128'd8);
    check("full_pop_drop",  128'(o_drop_count), 128'd3);
    drain("burst", 200);

    // Reset mid-hash after beat 1
    i_valid = 1'b1; i_hash = HASH_C;
    exp_q.push_back({1'b0, HASH_C[127:96]});
    exp_q.push_back({1'b0, HASH_C[95:64]});
    next_cycle();              // cycle 1
    i_valid = 1'b0;
    next_cycle();              // cycle 2: beat 0
    next_cycle();              // cycle 3: beat 1
    next_cycle();              // cycle 4: beat 2 showing, reset now
    rst = 1'b1; o_ready = 1'b0; i_valid = 1'b1; i_hash = HASH_D;
    next_cycle();
    rst = 1'b0; i_valid = 1'b0;
    check("midrst_valid", 128'(o_valid), 128'd0);
    check("midrst_level", 128'(o_level), 128'd0);
    check("midrst_drop",  128'(o_drop_count), 128'd0);
    check("midrst_sb",    128'(exp_q.size()), 128'd0);
    next_cycle();
    check("midrst_ignored_push", 128'(o_level), 128'd0);
    o_ready = 1'b1; i_valid = 1'b1; i_hash = HASH_E; expect_hash(HASH_E);
    next_cycle();
    i_valid = 1'b0;
    drain("post_rst", 50);

    // Drop counter saturation
    o_ready = 1'b0; i_valid = 1'b1;
    for (int i = 0; i < 70010; i++) begin
      i_hash = 128'(i);
      next_cycle();
    end
    i_valid = 1'b0;
    check("sat_drop", 128'(o_drop_count), 128'hFFFF);
    next_cycle();
    check("sat_hold", 128'(o_drop_count), 128'hFFFF);
    check("sat_level", 128'(o_level), 128'd8);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    next_cycle();
    check("final_drop", 128'(o_drop_count), 128'd0);
    check("final_sb",   128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
